// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// 8N1 UART transmitter. Serialises one byte per accepted Send onto Tx, LSB
// first, with each bit held for Full clock cycles.
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit follows the data bits (8E1).
// All outputs are registered. Reset is asynchronous and active-high; it
// forces Tx high and aborts any frame in flight without a Done pulse.
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int             N    = 14,
  parameter logic [N-1:0]   Full = 14'd10417
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] Data,
  input  logic       Send,
  output logic       Busy,
  output logic       Done,
  output logic       Tx
);

  localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO_C = {N{1'b0}};
  localparam logic [N-1:0] LAST_C = Full - ONE_C;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t       state_r, state_s;
  logic [N-1:0] cnt_r,   cnt_s;
  logic [2:0]   idx_r,   idx_s;
  logic [7:0]   shift_r, shift_s;
  logic         tx_r,    tx_s;
  logic         busy_r,  busy_s;
  logic         done_r,  done_s;
  logic         cnt_last_s;
`ifdef UART_TX_PARITY_EN
  logic         par_r,   par_s;
`endif

  assign Tx   = tx_r;
  assign Busy = busy_r;
  assign Done = done_r;

  // Compare is N bits wide so Full is effectively truncated to N bits.
  assign cnt_last_s = (cnt_r == LAST_C);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s = ZERO_C;
        if (Send) begin
          // Byte (and its parity) is captured here; the Data port is
          // ignored for the rest of the frame.
          shift_s = Data;
`ifdef UART_TX_PARITY_EN
          par_s   = even_parity(Data);
`endif
          tx_s    = 1'b0;
          busy_s  = 1'b1;
          state_s = START;
        end else begin
          tx_s    = 1'b1;
          busy_s  = 1'b0;
        end
      end
      START: begin
        if (cnt_last_s) begin
          cnt_s   = ZERO_C;
          tx_s    = shift_r[0];
          idx_s   = 3'd0;
          state_s = DATA;
        end else begin
          cnt_s   = cnt_r + ONE_C;
        end
      end
      DATA: begin
        if (cnt_last_s) begin
          cnt_s = ZERO_C;
          if (idx_r != 3'd7) begin
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
            idx_s   = idx_r + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_s    = par_r;
            state_s = PARITY;
`else
            tx_s    = 1'b1;
            state_s = STOP;
`endif
          end
        end else begin
          cnt_s = cnt_r + ONE_C;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_last_s) begin
          cnt_s   = ZERO_C;
          tx_s    = 1'b1;
          state_s = STOP;
        end else begin
          cnt_s   = cnt_r + ONE_C;
        end
      end
`endif
      STOP: begin
        if (cnt_last_s) begin
          // Busy drops for the Done cycle, letting a held Send restart
          // on the very next edge with no extra idle time.
          cnt_s   = ZERO_C;
          tx_s    = 1'b1;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + ONE_C;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_C;
        idx_s   = 3'd0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset returns the line to idle.
  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= ZERO_C;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Directed stimulus pushes expected bytes into a scoreboard queue; a monitor
// captures Tx while Busy is high and, on each Done, checks the waveform and
// the decoded byte against the popped entry. Honours UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int FULL = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       Clk_100M = 1'b0;
  logic       Reset    = 1'b1;
  logic [7:0] Data     = 8'h00;
  logic       Send     = 1'b0;
  logic       Busy, Done, Tx;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  logic cap_q[$];
  int   vectors = 0;
  int   errors  = 0;

  uart_transmitter #(.N(14), .Full(14'd4)) dut (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .Data     (Data),
    .Send     (Send),
    .Busy     (Busy),
    .Done     (Done),
    .Tx       (Tx)
  );

  always #5 Clk_100M = ~Clk_100M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  // Monitor / receiver model: capture Tx while Busy, judge each frame on Done.
  always @(negedge Clk_100M) begin
    if (Reset) begin
      cap_q.delete();
    end else begin
      if (Busy) cap_q.push_back(Tx);
      if (Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic [NBITS-1:0] bits;
          logic [7:0] rx;
          int mism;
          e = exp_q.pop_front();
          check("frame_len", cap_q.size(), NBITS * FULL);
          if (cap_q.size() == NBITS * FULL) begin
            bits[0] = 1'b0;
            for (int k = 0; k < 8; k++) bits[k+1] = e.data[k];
`ifdef UART_TX_PARITY_EN
            bits[9] = e.par;
`endif
            bits[NBITS-1] = 1'b1;
            mism = 0;
            for (int i = 0; i < NBITS * FULL; i++)
              if (cap_q[i] !== bits[i / FULL]) mism++;
            check("tx_wave", mism, 0);
            for (int k = 0; k < 8; k++) rx[k] = cap_q[FULL * (k + 1) + FULL / 2];
            check("rx_byte", rx, e.data);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", cap_q[FULL * 9 + FULL / 2], e.par);
`endif
          end
        end
        cap_q.delete();
      end
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge Clk_100M);
    check(name, exp_q.size(), 0);
    repeat (4) @(negedge Clk_100M);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle line.
    repeat (3) @(negedge Clk_100M);
    check("reset_state", {Tx, Busy, Done}, 3'b100);
    Reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk_100M);
      check("idle", {Tx, Busy, Done}, 3'b100);
    end

    // Single-cycle Send of 8'h55.
    Data = 8'h55; Send = 1'b1; push(8'h55, 1'b0);
    @(negedge Clk_100M);
    Send = 1'b0;
    check("busy_after_accept", {Tx, Busy}, 2'b01);
    drain("drain_55");

    // Held Send: two back-to-back 8'hA3 frames; mid-frame Data change ignored.
    Data = 8'hA3; Send = 1'b1; push(8'hA3, 1'b0); push(8'hA3, 1'b0);
    for (int p = 1; p <= 50; p++) begin
      @(negedge Clk_100M);
      if (p == 10) Data = 8'h00;
      if (p == 30) Data = 8'hA3;
      if (p == 41) check("b2b_done_gap", {Done, Busy}, 2'b10);
      if (p == 42) check("b2b_restart", {Tx, Busy, Done}, 3'b010);
      if (p == 50) Send = 1'b0;
    end
    drain("drain_a3");

    // Reset mid-frame aborts with no Done, then a clean 8'h0F frame.
    Data = 8'hFF; Send = 1'b1;
    @(negedge Clk_100M);
    Send = 1'b0;
    repeat (16) @(posedge Clk_100M);
    #2 Reset = 1'b1;
    #1 check("abort_async", {Tx, Busy, Done}, 3'b100);
    repeat (2) @(negedge Clk_100M);
    Reset = 1'b0;
    repeat (2) @(negedge Clk_100M);
    check("after_abort_idle", {Tx, Busy, Done}, 3'b100);
    Data = 8'h0F; Send = 1'b1; push(8'h0F, 1'b0);
    @(negedge Clk_100M);
    Send = 1'b0;
    drain("drain_0f");

    // Send pulses during a frame are ignored.
    Data = 8'h3C; Send = 1'b1; push(8'h3C, 1'b0);
    @(negedge Clk_100M);
    Send = 1'b0;
    for (int p = 2; p <= 30; p++) begin
      @(negedge Clk_100M);
      if (p == 5)  begin Data = 8'hFF; Send = 1'b1; end
      if (p == 6)  Send = 1'b0;
      if (p == 25) begin Data = 8'h81; Send = 1'b1; end
      if (p == 26) Send = 1'b0;
    end
    drain("drain_3c");
    repeat (60) @(negedge Clk_100M);
    check("no_extra_frame", Busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    Data = 8'h07; Send = 1'b1; push(8'h07, 1'b1);
    @(negedge Clk_100M);
    Send = 1'b0;
    drain("drain_07");
    Data = 8'h03; Send = 1'b1; push(8'h03, 1'b0);
    @(negedge Clk_100M);
    Send = 1'b0;
    drain("drain_03");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
